// File: rtl/design_lane_arbiter.sv
// -----------------------------------------------------------------------------
// design_lane_arbiter
//
// Shares one instance of the 7-lane combinational `design` datapath among N
// requesters. A round-robin arbiter picks one requester per IDLE visit and
// registers its operands onto the datapath inputs. The inputs are then held for
// SETTLE_CYCLES full cycles so the long combinational path can resolve. After
// that the result is captured and returned on a valid/ready response port,
// tagged with the requester ID.
//
// Parameters
//   N              number of requesters (2..8)
//   ID_W           requester ID width, must equal clog2(N)
//   SETTLE_CYCLES  cycles the datapath inputs are held before capture (1..15)
//   CNT_W          width of the completed-transaction counter
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active high
//   req        in   [N]       per-requester request level (sampled in IDLE only)
//   req_a      in   [7N]      operand A, requester k at [7k+6:7k]
//   req_b      in   [7N]      operand B, same packing
//   req_ctl    in   [15N]     control word, requester k at [15k+14:15k]
//   gnt        out  [N]       one-hot, one-cycle acceptance pulse
//   dp_a       out  [7]       datapath I1..I7 (bit0 = I1)
//   dp_b       out  [7]       datapath I8..I14
//   dp_ctl     out  [15]      datapath I15..I29
//   dp_result  in   [7]       datapath O1..O7
//   rsp_valid  out            response valid
//   rsp_ready  in             response consumer ready
//   rsp_id     out  [ID_W]    requester owning the response
//   rsp_data   out  [7]       captured dp_result
//   busy       out            high whenever the controller is not IDLE
//   txn_count  out  [CNT_W]   completed responses, wraps
// -----------------------------------------------------------------------------
module design_lane_arbiter #(
    parameter int N             = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [7*N-1:0]      req_a,
    input  logic [7*N-1:0]      req_b,
    input  logic [15*N-1:0]     req_ctl,
    output logic [N-1:0]        gnt,
    output logic [6:0]          dp_a,
    output logic [6:0]          dp_b,
    output logic [14:0]         dp_ctl,
    input  logic [6:0]          dp_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [6:0]          rsp_data,
    output logic                busy,
    output logic [CNT_W-1:0]    txn_count
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter guards
    // -------------------------------------------------------------------------
    generate
        if (N < 2 || N > 8) begin : g_bad_n
            $error("design_lane_arbiter: N must be in 2..8");
        end
        if (ID_W != $clog2(N)) begin : g_bad_id_w
            $error("design_lane_arbiter: ID_W must equal clog2(N)");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("design_lane_arbiter: SETTLE_CYCLES must be in 1..15");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("design_lane_arbiter: CNT_W must be at least 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Local constants and types
    // -------------------------------------------------------------------------
    localparam int SC_W = 4;
    // The counter is loaded with SETTLE_CYCLES-1 at the grant edge and the
    // capture happens on the edge that sees zero, which places the capture
    // exactly SETTLE_CYCLES edges after the grant.
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
    // Pointer starts at N-1 so requester 0 is searched first after reset.
    localparam logic [ID_W-1:0] LAST_RESET  = ID_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [ID_W-1:0]    last_q,      last_d;
    logic [SC_W-1:0]    cnt_q,       cnt_d;
    logic [N-1:0]       gnt_q,       gnt_d;
    logic [6:0]         dp_a_q,      dp_a_d;
    logic [6:0]         dp_b_q,      dp_b_d;
    logic [14:0]        dp_ctl_q,    dp_ctl_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
    logic [6:0]         rsp_data_q,  rsp_data_d;
    logic [CNT_W-1:0]   txn_count_q, txn_count_d;

    // -------------------------------------------------------------------------
    // Round-robin winner selection
    //
    // Requests strictly above the last winner get first look; if none exist
    // the search wraps and takes the lowest set request overall. The lowest
    // set bit of the chosen vector is isolated with x & -x.
    // -------------------------------------------------------------------------
    logic [N-1:0]               upper_mask;
    logic [N-1:0]               req_upper;
    logic [N-1:0]               pick_src;
    logic [N-1:0]               pick_oh;

    // Transposed AND terms: [bit][lane]. Each selected field bit is the OR over
    // lanes, which keeps every select constant and the mux one-hot AND-OR.
    logic [6:0][N-1:0]          a_terms;
    logic [6:0][N-1:0]          b_terms;
    logic [14:0][N-1:0]         ctl_terms;
    logic [ID_W-1:0][N-1:0]     id_terms;

    logic [6:0]                 sel_a;
    logic [6:0]                 sel_b;
    logic [14:0]                sel_ctl;
    logic [ID_W-1:0]            win_id;

    genvar gi, gb;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            localparam logic [ID_W-1:0] LANE_ID = ID_W'(gi);

            assign upper_mask[gi] = (LANE_ID > last_q);

            for (gb = 0; gb < 7; gb++) begin : g_ab
                assign a_terms[gb][gi] = pick_oh[gi] & req_a[7*gi + gb];
                assign b_terms[gb][gi] = pick_oh[gi] & req_b[7*gi + gb];
            end

            for (gb = 0; gb < 15; gb++) begin : g_ctl
                assign ctl_terms[gb][gi] = pick_oh[gi] & req_ctl[15*gi + gb];
            end

            for (gb = 0; gb < ID_W; gb++) begin : g_id
                assign id_terms[gb][gi] = pick_oh[gi] & LANE_ID[gb];
            end
        end

        for (gb = 0; gb < 7; gb++) begin : g_sel_ab
            assign sel_a[gb] = |a_terms[gb];
            assign sel_b[gb] = |b_terms[gb];
        end

        for (gb = 0; gb < 15; gb++) begin : g_sel_ctl
            assign sel_ctl[gb] = |ctl_terms[gb];
        end

        for (gb = 0; gb < ID_W; gb++) begin : g_sel_id
            assign win_id[gb] = |id_terms[gb];
        end
    endgenerate

    assign req_upper = req & upper_mask;
    assign pick_src  = (|req_upper) ? req_upper : req;
    assign pick_oh   = pick_src & (~pick_src + N'(1));

    // -------------------------------------------------------------------------
    // Register process
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= LAST_RESET;
            cnt_q       <= '0;
            gnt_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_ctl_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_ctl_q    <= dp_ctl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            txn_count_q <= txn_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath register logic
    //
    // Everything holds by default; gnt is the only field that self-clears,
    // which makes it a single-cycle pulse.
    // -------------------------------------------------------------------------
    always_comb begin
        last_d      = last_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        dp_ctl_d    = dp_ctl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        txn_count_d = txn_count_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d    = pick_oh;
                    dp_a_d   = sel_a;
                    dp_b_d   = sel_b;
                    dp_ctl_d = sel_ctl;
                    last_d   = win_id;
                    rsp_id_d = win_id;
                    cnt_d    = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SC_W'(1);
                end else begin
                    rsp_data_d  = dp_result;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Port drives
    // -------------------------------------------------------------------------
    assign gnt       = gnt_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_ctl    = dp_ctl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign txn_count = txn_count_q;

endmodule

// File: doc/design_lane_arbiter.md
Name: design_lane_arbiter

Overview:
- Shares one instance of the 7-lane combinational `design` datapath among N requesters, using round-robin arbitration.
- The datapath takes operand A (I1..I7), operand B (I8..I14) and a 15-bit control word (I15..I29), and returns result O1..O7.
- This block registers the winner's operands onto the datapath inputs and waits a fixed settle time for the 350+ gate path to resolve.
- It then captures the result and returns it on a valid/ready response port, tagged with the requester ID.

Parameters:
- N, 4, number of requesters (2..8).
- ID_W, 2, requester ID width, equal to clog2(N).
- SETTLE_CYCLES, 2, clock cycles the datapath inputs are held before result capture (1..15).
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N  per-requester request level.
- req_a  in  7*N  operand A per requester; requester k uses bits [7k+6:7k].
- req_b  in  7*N  operand B per requester, same packing.
- req_ctl  in  15*N  control word per requester, same packing at width 15.
- gnt  out  N  one-hot, one-cycle acceptance pulse.
- dp_a  out  7  to datapath I1..I7; bit0 = I1.
- dp_b  out  7  to datapath I8..I14.
- dp_ctl  out  15  to datapath I15..I29.
- dp_result  in  7  from datapath O1..O7.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester that owns the response.
- rsp_data  out  7  captured dp_result.
- busy  out  1  high whenever state is not IDLE.
- txn_count  out  CNT_W  number of completed responses; wraps.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - gnt=0, dp_a=0, dp_b=0, dp_ctl=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - txn_count=0, busy=0, state=IDLE.
  - Round-robin pointer last=N-1, so requester 0 has first priority.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - req is sampled only in IDLE.
  - If req!=0, the winner w is the first set bit searching upward from last+1, modulo N.
  - At the edge: dp_a/dp_b/dp_ctl <= slice w; gnt <= onehot(w) for exactly one cycle; last <= w; rsp_id <= w; cnt <= SETTLE_CYCLES-1; state -> SETTLE.
  - If req==0, nothing changes.
- SETTLE:
  - dp_* are held stable.
  - If cnt!=0, decrement cnt.
  - If cnt==0: rsp_data <= dp_result, rsp_valid <= 1, state -> RESP.
- Latency: the capture edge is SETTLE_CYCLES edges after the grant edge, so dp_* are stable for exactly SETTLE_CYCLES full cycles before sampling.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable while rsp_ready=0.
  - On an edge with rsp_valid && rsp_ready: rsp_valid <= 0, txn_count <= txn_count+1 (wraps at 2^CNT_W), state -> IDLE.
  - dp_* keep their last value; they change only on the next grant.
- Throughput: the best case is one transaction per SETTLE_CYCLES+2 cycles, with rsp_ready tied high.
- Requester contract: a requester must hold its slice stable while its req is high. It deasserts req, or presents new operands, after seeing its gnt pulse. A req still high at the next IDLE is treated as a new request.
- Simultaneous requests: only one grant is issued per IDLE visit. Fairness is round-robin, so with all N requesting, each requester is granted once every N transactions.
- req changes during SETTLE or RESP have no effect.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation: the transaction is abandoned, no response is produced, txn_count is not incremented, and all registers return to their reset values.
- Out-of-range parameters (SETTLE_CYCLES=0, N<2) are compile-time errors.

Test Plan:
- Reset, then req=4'b0001, A=7'h55, B=7'h2A, ctl=15'h0000 -> gnt=0001 pulses 1 cycle; dp_a=55, dp_b=2A for 2 cycles; rsp_valid rises 2 edges after the grant edge; rsp_id=0; rsp_data equals the golden-model `design` output; txn_count=1.
- req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; exactly one gnt bit high per transaction; transactions spaced 4 cycles apart.
- rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_data stay constant; no new gnt; busy=1; completion occurs on the first cycle with rsp_ready=1.
- Toggle req_a of the granted requester during SETTLE -> dp_a unchanged; rsp_data matches the operands latched at grant.
- Assert rst during SETTLE with SETTLE_CYCLES=4 -> next cycle all outputs are 0; no rsp_valid; txn_count unchanged at 0; requester 0 has priority again.
- Run 65537 transactions with rsp_ready=1 -> txn_count wraps to 1.
